// File: rtl/cpu_exc_pkg.sv
// rtl/cpu_exc_pkg.sv - shared types and constants for the exception sequencer
package cpu_exc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SAVE = 2'd1,
        ST_WAIT = 2'd2,
        ST_LOAD = 2'd3
    } exc_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_OPCODE   = 2'd1,
        CAUSE_OVERFLOW = 2'd2,
        CAUSE_DIVZERO  = 2'd3
    } exc_cause_t;

    localparam logic [7:0] EXC_VEC_OPCODE = 8'd253;
    localparam logic [7:0] EXC_VEC_OVF    = 8'd254;
    localparam logic [7:0] EXC_VEC_DIV0   = 8'd255;

    localparam logic [1:0] MUX_MEM_NORMAL = 2'd0;
    localparam logic [1:0] MUX_MEM_EXC    = 2'd3;

    localparam logic [1:0] MUX_EXC_OPCODE = 2'd0;
    localparam logic [1:0] MUX_EXC_OVF    = 2'd1;
    localparam logic [1:0] MUX_EXC_DIV0   = 2'd2;

    // Vector mux select that addresses the handler byte for a given cause.
    function automatic logic [1:0] cause_to_mux_exc(exc_cause_t c);
        case (c)
            CAUSE_OVERFLOW: return MUX_EXC_OVF;
            CAUSE_DIVZERO:  return MUX_EXC_DIV0;
            default:        return MUX_EXC_OPCODE;
        endcase
    endfunction

endpackage

// File: rtl/exc_sequencer_if.sv
// rtl/exc_sequencer_if.sv - request, memory and datapath-control bundle of the exception sequencer
interface exc_sequencer_if;
    logic        exc_opcode;
    logic        exc_overflow;
    logic        exc_divzero;
    logic [7:0]  mem_data;
    logic        busy;
    logic        epc_w;
    logic [1:0]  mux_exc;
    logic [1:0]  mux_mem;
    logic        pc_w;
    logic [31:0] handler_addr;
    logic [1:0]  cause;
    logic        nested_err;

    modport master (
        input  exc_opcode, exc_overflow, exc_divzero, mem_data,
        output busy, epc_w, mux_exc, mux_mem, pc_w, handler_addr, cause, nested_err
    );

    modport slave (
        output exc_opcode, exc_overflow, exc_divzero, mem_data,
        input  busy, epc_w, mux_exc, mux_mem, pc_w, handler_addr, cause, nested_err
    );
endinterface

// File: rtl/exc_priority_enc.sv
// rtl/exc_priority_enc.sv - fixed-priority encoder from request lines to exception cause
module exc_priority_enc
    import cpu_exc_pkg::*;
(
    input  logic       exc_opcode,
    input  logic       exc_overflow,
    input  logic       exc_divzero,
    output exc_cause_t cause
);

    always_comb begin
        cause = CAUSE_NONE;
        if (exc_opcode)        cause = CAUSE_OPCODE;
        else if (exc_overflow) cause = CAUSE_OVERFLOW;
        else if (exc_divzero)  cause = CAUSE_DIVZERO;
    end

endmodule

// File: rtl/exc_sequencer.sv
// rtl/exc_sequencer.sv - multicycle EPC save / vector fetch / PC load sequencer
module exc_sequencer
    import cpu_exc_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic            clk,
    input  logic            reset,
    exc_sequencer_if.master bus
);

    localparam logic [2:0] WAIT_INIT = 3'(MEM_LAT - 1);

    exc_state_t  state;
    exc_cause_t  cause_q;
    exc_cause_t  req_cause;
    logic [2:0]  wait_cnt;
    logic        epc_w_q;
    logic        pc_w_q;
    logic        nested_q;
    logic [31:0] handler_q;
    logic        req_any;

    exc_priority_enc u_enc (
        .exc_opcode   (bus.exc_opcode),
        .exc_overflow (bus.exc_overflow),
        .exc_divzero  (bus.exc_divzero),
        .cause        (req_cause)
    );

    assign req_any = (req_cause != CAUSE_NONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cause_q   <= CAUSE_NONE;
            wait_cnt  <= 3'd0;
            epc_w_q   <= 1'b0;
            pc_w_q    <= 1'b0;
            nested_q  <= 1'b0;
            handler_q <= 32'd0;
        end else begin
            epc_w_q <= 1'b0;
            pc_w_q  <= 1'b0;
            if (state != ST_IDLE && req_any)
                nested_q <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (req_any) begin
                        cause_q <= req_cause;
                        epc_w_q <= 1'b1;
                        state   <= ST_SAVE;
                    end
                end
                ST_SAVE: begin
                    wait_cnt <= WAIT_INIT;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // The edge leaving WAIT is the one at which mem_data is valid.
                    if (wait_cnt == 3'd0) begin
                        handler_q <= {24'd0, bus.mem_data};
                        pc_w_q    <= 1'b1;
                        state     <= ST_LOAD;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                ST_LOAD: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy         = (state != ST_IDLE);
    assign bus.mux_mem      = (state != ST_IDLE) ? MUX_MEM_EXC : MUX_MEM_NORMAL;
    assign bus.mux_exc      = (state == ST_SAVE || state == ST_WAIT) ? cause_to_mux_exc(cause_q)
                                                                     : MUX_EXC_OPCODE;
    assign bus.epc_w        = epc_w_q;
    assign bus.pc_w         = pc_w_q;
    assign bus.handler_addr = handler_q;
    assign bus.cause        = cause_q;
    assign bus.nested_err   = nested_q;

endmodule

// File: tb/tb_exc_sequencer.sv
// tb/tb_exc_sequencer.sv - self-checking bench for exc_sequencer at MEM_LAT 1 and 3
module tb_exc_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    exc_sequencer_if bus1 ();
    exc_sequencer_if bus3 ();

    exc_sequencer #(.MEM_LAT(1)) u_l1 (.clk(clk), .reset(reset), .bus(bus1));
    exc_sequencer #(.MEM_LAT(3)) u_l3 (.clk(clk), .reset(reset), .bus(bus3));

    always #5 clk = ~clk;

    // Timeline model: phase counts edges since the accepting edge.
    int          lat [2] = '{1, 3};
    bit          m_active [2];
    int          m_phase [2];
    logic [1:0]  m_cause [2];
    logic [31:0] m_handler [2];
    bit          m_nested [2];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_active[d]  = 0;
            m_phase[d]   = 0;
            m_cause[d]   = 2'd0;
            m_handler[d] = 32'd0;
            m_nested[d]  = 0;
        end
    endtask

    task automatic model_step(int d, logic op, logic ov, logic dz, logic [7:0] md);
        if (m_active[d]) begin
            if (op || ov || dz) m_nested[d] = 1;
            m_phase[d]++;
            if (m_phase[d] == lat[d] + 1) m_handler[d] = {24'd0, md};
            if (m_phase[d] == lat[d] + 2) m_active[d] = 0;
        end else if (op || ov || dz) begin
            m_active[d] = 1;
            m_phase[d]  = 0;
            m_cause[d]  = op ? 2'd1 : (ov ? 2'd2 : 2'd3);
        end
    endtask

    task automatic check_one(int d, logic busy, logic epc_w, logic [1:0] mux_exc,
                             logic [1:0] mux_mem, logic pc_w, logic [31:0] ha,
                             logic [1:0] cause, logic nested);
        string p;
        bit    in_seq;
        p = $sformatf("L%0d.", lat[d]);
        in_seq = m_active[d];
        chk({p, "busy"}, 32'(busy), 32'(in_seq));
        chk({p, "epc_w"}, 32'(epc_w), 32'(in_seq && m_phase[d] == 0));
        chk({p, "pc_w"}, 32'(pc_w), 32'(in_seq && m_phase[d] == lat[d] + 1));
        chk({p, "mux_mem"}, 32'(mux_mem), in_seq ? 32'd3 : 32'd0);
        chk({p, "mux_exc"}, 32'(mux_exc),
            (in_seq && m_phase[d] <= lat[d]) ? 32'(m_cause[d] - 2'd1) : 32'd0);
        chk({p, "handler_addr"}, ha, m_handler[d]);
        chk({p, "cause"}, 32'(cause), 32'(m_cause[d]));
        chk({p, "nested_err"}, 32'(nested), 32'(m_nested[d]));
    endtask

    task automatic check_all();
        check_one(0, bus1.busy, bus1.epc_w, bus1.mux_exc, bus1.mux_mem, bus1.pc_w,
                  bus1.handler_addr, bus1.cause, bus1.nested_err);
        check_one(1, bus3.busy, bus3.epc_w, bus3.mux_exc, bus3.mux_mem, bus3.pc_w,
                  bus3.handler_addr, bus3.cause, bus3.nested_err);
    endtask

    task automatic step(logic op, logic ov, logic dz, logic [7:0] md);
        bus1.exc_opcode = op; bus1.exc_overflow = ov; bus1.exc_divzero = dz; bus1.mem_data = md;
        bus3.exc_opcode = op; bus3.exc_overflow = ov; bus3.exc_divzero = dz; bus3.mem_data = md;
        model_step(0, op, ov, dz, md);
        model_step(1, op, ov, dz, md);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("L3.wait_cnt_reset", 32'(u_l3.wait_cnt), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_all();
    endtask

    initial begin
        int bc;
        step_init: begin
            bus1.exc_opcode = 0; bus1.exc_overflow = 0; bus1.exc_divzero = 0; bus1.mem_data = 8'h00;
            bus3.exc_opcode = 0; bus3.exc_overflow = 0; bus3.exc_divzero = 0; bus3.mem_data = 8'h00;
        end
        model_reset();
        @(negedge clk);
        do_reset();

        for (int i = 0; i < 10; i++) step(0, 0, 0, 8'($urandom));

        // Overflow, handler byte 0x40
        step(0, 1, 0, 8'h40);
        chk("ovf.epc_w", 32'(bus1.epc_w), 32'd1);
        chk("ovf.mux_exc", 32'(bus1.mux_exc), 32'd1);
        chk("ovf.mux_mem", 32'(bus1.mux_mem), 32'd3);
        bc = 1;
        step(0, 0, 0, 8'h40);
        if (bus1.busy) bc++;
        step(0, 0, 0, 8'h40);
        if (bus1.busy) bc++;
        chk("ovf.pc_w", 32'(bus1.pc_w), 32'd1);
        chk("ovf.handler", bus1.handler_addr, 32'h40);
        chk("ovf.cause", 32'(bus1.cause), 32'd2);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 8'($urandom));
            if (bus1.busy) bc++;
        end
        chk("ovf.busy_len_l1", 32'(bc), 32'd3);

        // Simultaneous opcode and divzero
        step(1, 0, 1, 8'hA5);
        chk("simul.mux_exc", 32'(bus1.mux_exc), 32'd0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 8'hA5);
        chk("simul.cause", 32'(bus3.cause), 32'd1);
        chk("simul.nested", 32'(bus3.nested_err), 32'd0);

        // Divzero, busy length at MEM_LAT=3
        step(0, 0, 1, 8'h9C);
        chk("div0.mux_exc", 32'(bus3.mux_exc), 32'd2);
        bc = bus3.busy ? 1 : 0;
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 0, 8'h9C);
            if (bus3.busy) bc++;
            if (i == 3) chk("div0.pc_w_cycle5", 32'(bus3.pc_w), 32'd1);
        end
        chk("div0.busy_len_l3", 32'(bc), 32'd5);
        chk("div0.handler", bus3.handler_addr, 32'h9C);

        // Request during WAIT sets sticky nested_err
        step(0, 0, 1, 8'h11);
        step(0, 0, 0, 8'h11);
        step(0, 1, 0, 8'h11);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 8'h22);
        chk("nested.l1", 32'(bus1.nested_err), 32'd1);
        chk("nested.l3", 32'(bus3.nested_err), 32'd1);
        chk("nested.cause", 32'(bus3.cause), 32'd3);

        // Reset in the middle of WAIT
        step(1, 0, 0, 8'h33);
        step(0, 0, 0, 8'h33);
        step(0, 0, 0, 8'h33);
        do_reset();
        for (int i = 0; i < 6; i++) step(0, 0, 0, 8'h44);
        step(0, 1, 0, 8'h55);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 8'h55);
        chk("post_reset.handler", bus3.handler_addr, 32'h55);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 79) == 0) do_reset();
            else step($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                      $urandom_range(0, 9) == 0, 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exc_sequencer.md
# exc_sequencer

Multicycle exception sequencer for the MIPS-subset CPU. It takes over the datapath when `control_unit` flags an invalid opcode, an ALU overflow or a divide-by-zero. It then runs the fixed exception sequence:
- save the faulting address into EPC;
- read the handler byte from the vector address (253/254/255) via the exception address mux and memory;
- zero-extend that byte and load it into PC.

It sits beside `control_unit` and freezes it with `busy` while it owns the EPC, memory-address and PC control lines.

## Interface
Parameters:
- MEM_LAT, 1, memory read latency in cycles from address valid to `mem_data` valid; legal range 1–7.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- exc_opcode  in  1  invalid-opcode request, single-cycle pulse from `control_unit`.
- exc_overflow  in  1  ALU overflow request, pulse.
- exc_divzero  in  1  divide-by-zero request, pulse.
- mem_data  in  8  `MEM_out[7:0]`, the handler byte.
- busy  out  1  sequencer owns the datapath; `control_unit` holds state while high.
- epc_w  out  1  EPC write enable.
- mux_exc  out  2  exception vector select: 0→253, 1→254, 2→255.
- mux_mem  out  2  memory address mux select; 3 = exception vector, else 0.
- pc_w  out  1  PC write enable.
- handler_addr  out  32  `{24'b0, mem_data}`, registered, PC source during `pc_w`.
- cause  out  2  last accepted cause: 0 none, 1 opcode, 2 overflow, 3 divzero.
- nested_err  out  1  sticky; a request arrived while `busy`.

## Operation
- States: IDLE, SAVE, WAIT, LOAD.
- IDLE:
  - any request → latch cause by priority opcode > overflow > divzero, go to SAVE;
  - lower-priority simultaneous requests are dropped silently.
- SAVE (1 cycle): `epc_w=1`; `mux_mem=3`; `mux_exc` = cause−1.
- WAIT: MEM_LAT cycles driven by a 3-bit down-counter; `mux_mem=3` and `mux_exc` held.
- LOAD (1 cycle):
  - `handler_addr` register captures `{24'b0, mem_data}` on entry to LOAD; it is stable throughout LOAD.
  - `pc_w=1`; `mux_mem=3` still held.
  - Next state IDLE.
- `busy`=1 in SAVE, WAIT and LOAD; 0 in IDLE.
- `mux_mem`=0, `mux_exc`=0, `epc_w`=0, `pc_w`=0 whenever not specified above.
- Requests while `busy`: ignored for sequencing; set `nested_err` (cleared only by reset).
- `cause` holds its value after LOAD until the next accepted request.
- Memory is never written by this block; `MEM_w` stays under `control_unit` control and `control_unit` must keep it 0 while `busy`.

## Timing
- Reset values: state IDLE, busy 0, epc_w 0, pc_w 0, mux_exc 0, mux_mem 0, handler_addr 0, cause 0, nested_err 0, counter 0.
- Request sampled at edge k; SAVE during cycle k+1; WAIT cycles k+2..k+1+MEM_LAT; LOAD at cycle k+2+MEM_LAT.
- PC updated at the end of LOAD. Total latency request→PC updated = MEM_LAT+2 cycles after sampling; `busy` is high for MEM_LAT+2 cycles.
- `mem_data` must be valid at the last WAIT edge, which is the edge entering LOAD.
- A request in the cycle `busy` falls (first IDLE cycle) is accepted normally.
- Reset asserted in any state: all outputs go to reset values immediately (asynchronous); a partial sequence is abandoned and EPC may already be written.
- All outputs are registered except `busy`, `mux_mem` and `mux_exc`, which decode from state and cause registers (glitch-free, no input-to-output combinational path).

## Structure
- Shared package `cpu_exc_pkg`:
  - state enum `exc_state_t`;
  - cause enum `exc_cause_t` (NONE/OPCODE/OVERFLOW/DIVZERO);
  - vector constants `EXC_VEC_OPCODE=253`, `EXC_VEC_OVF=254`, `EXC_VEC_DIV0=255`;
  - `MUX_MEM_EXC=2'd3`; `mux_exc` encodings.
- One sub-module: `exc_priority_enc` (3 request lines → `exc_cause_t`), combinational.
- Wait counter and FSM stay in the top module.

## Test plan
- Reset then idle 10 cycles → all outputs 0, `busy`=0.
- `exc_overflow` pulse, MEM_LAT=1, `mem_data`=8'h40 → cycle+1: `epc_w`=1, `mux_exc`=1, `mux_mem`=3; cycle+3: `pc_w`=1, `handler_addr`=32'h40, `cause`=2.
- `exc_opcode` and `exc_divzero` in the same cycle → `cause`=1, `mux_exc`=0; divzero dropped; `nested_err`=0.
- MEM_LAT=3, `exc_divzero` → WAIT lasts 3 cycles, `busy` high 5 cycles, `mux_exc`=2, `pc_w` in cycle+5.
- `exc_overflow` pulse during WAIT → sequence unaffected, `nested_err`=1 and sticky until reset.
- Reset asserted mid-WAIT → `busy`, `mux_mem` and counter 0 immediately; no `pc_w` pulse; next request runs a full sequence.
